// File: rtl/lifo_fifo_buffer.sv
// lifo_fifo_buffer
//   Runtime-selectable stack (LIFO) / queue (FIFO) buffer of DEPTH words of
//   WIDTH bits, with occupancy count, almost-full threshold, a registered
//   read-valid strobe and sticky overflow/underflow flags.
//
//   Optional feature macro: LIFO_FIFO_BUFFER_FIFO_MODE_EN
//     defined   : MODE selects LIFO (0) or FIFO (1)
//     undefined : LIFO only; FIFO pointers are not built, MODE is ignored and
//                 ACT_MODE is tied to 0
//
// Ports
//   Clk          rising-edge clock
//   Rst          asynchronous active-low reset
//   MODE         requested mode (0 = LIFO, 1 = FIFO)
//   PUSH / POP   write / read requests
//   CLR_ERR      clear sticky OVERFLOW/UNDERFLOW
//   dataIn       write data
//   dataOut      registered read data
//   VALID        one-cycle strobe, dataOut was updated by an accepted pop
//   EMPTY/FULL   COUNT == 0 / COUNT == DEPTH
//   ALMOST_FULL  COUNT >= AF_LEVEL
//   COUNT        current occupancy
//   ACT_MODE     mode currently in effect
//   OVERFLOW     sticky, a push was rejected
//   UNDERFLOW    sticky, a pop was rejected
module lifo_fifo_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     MODE,
  input  logic                     PUSH,
  input  logic                     POP,
  input  logic                     CLR_ERR,
  input  logic [WIDTH-1:0]         dataIn,
  output logic [WIDTH-1:0]         dataOut,
  output logic                     VALID,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ALMOST_FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     ACT_MODE,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             overflow;
  logic             underflow;
  logic             act_mode;
  logic             pop_ok;
  logic             push_ok;
  logic [AW-1:0]    lifo_top;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    wr_addr;

  // A push while full is still accepted when a pop frees the slot in the
  // same cycle; a pop on an empty buffer is always rejected (no bypass).
  assign pop_ok  = POP && (count != '0);
  assign push_ok = PUSH && ((count != DEPTH_C) || pop_ok);

  // Top of stack; at COUNT == DEPTH the low bits are 0 and this wraps to DEPTH-1.
  assign lifo_top = count[AW-1:0] - AW'(1);

`ifdef LIFO_FIFO_BUFFER_FIFO_MODE_EN
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          mode_load;

  // Mode may only change while empty and nothing is being written.
  assign mode_load = (count == '0) && !push_ok;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      act_mode <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (mode_load) begin
      act_mode <= MODE;
      if (MODE != act_mode) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end
    end else if (act_mode) begin
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Simultaneous LIFO push/pop overwrites the current top in place.
  assign rd_addr = act_mode ? rd_ptr : lifo_top;
  assign wr_addr = act_mode ? wr_ptr : (pop_ok ? lifo_top : count[AW-1:0]);
`else
  logic unused_mode;

  assign unused_mode = MODE;
  assign act_mode    = 1'b0;
  assign rd_addr     = lifo_top;
  assign wr_addr     = pop_ok ? lifo_top : count[AW-1:0];
`endif

  // Storage is deliberately not reset.
  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_addr] <= dataIn;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid <= pop_ok;
      // Read uses the pre-edge memory, so push+pop returns the old word.
      if (pop_ok) data_out <= mem[rd_addr];

      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);

      // A fresh error in the same cycle as CLR_ERR keeps the flag set.
      if (PUSH && !push_ok) overflow <= 1'b1;
      else if (CLR_ERR)     overflow <= 1'b0;

      if (POP && !pop_ok)   underflow <= 1'b1;
      else if (CLR_ERR)     underflow <= 1'b0;
    end
  end

  assign dataOut     = data_out;
  assign VALID       = valid;
  assign COUNT       = count;
  assign EMPTY       = (count == '0);
  assign FULL        = (count == DEPTH_C);
  assign ALMOST_FULL = (count >= AF_C);
  assign ACT_MODE    = act_mode;
  assign OVERFLOW    = overflow;
  assign UNDERFLOW   = underflow;

endmodule

// File: doc/lifo_fifo_buffer.md
Name: lifo_fifo_buffer

Overview:
Parametrised successor to the team's single-mode LIFO memory. Stores DEPTH words of WIDTH bits and operates as a stack (LIFO) or a queue (FIFO), selected at runtime. Adds occupancy count, almost-full threshold, registered read-valid strobe, sticky overflow/underflow flags and defined simultaneous push/pop behaviour. Sits between a producer and consumer in the datapath as a general-purpose buffer.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, 12, ALMOST_FULL asserts when COUNT >= AF_LEVEL (1..DEPTH)

Ports:
Clk  input  1  clock, rising-edge
Rst  input  1  asynchronous, active-low reset
MODE  input  1  requested mode: 0 = LIFO, 1 = FIFO
PUSH  input  1  write request
POP  input  1  read request
CLR_ERR  input  1  clear sticky error flags
dataIn  input  WIDTH  write data
dataOut  output  WIDTH  read data, registered
VALID  output  1  one-cycle strobe: dataOut updated
EMPTY  output  1  COUNT == 0
FULL  output  1  COUNT == DEPTH
ALMOST_FULL  output  1  COUNT >= AF_LEVEL
COUNT  output  $clog2(DEPTH)+1  current occupancy
ACT_MODE  output  1  mode currently in effect
OVERFLOW  output  1  sticky: push rejected
UNDERFLOW  output  1  sticky: pop rejected

Behaviour:
- Reset (Rst low, async): COUNT=0, EMPTY=1, FULL=0, ALMOST_FULL=0, dataOut=0, VALID=0, OVERFLOW=0, UNDERFLOW=0, ACT_MODE=0 (LIFO), all pointers 0. Memory contents not cleared. Reset mid-operation discards all entries.
- Flags EMPTY/FULL/ALMOST_FULL/COUNT are registered and reflect state after the last clock edge.
- Pop accepted: POP=1 and COUNT>0. Next edge: dataOut = popped word, VALID=1 for exactly that cycle. Latency 1 cycle.
- Pop rejected (COUNT==0): dataOut holds, VALID=0, UNDERFLOW set.
- Push accepted alone: PUSH=1 and COUNT<DEPTH; word written, COUNT+1.
- Push rejected (FULL, no accepted pop same cycle): memory and COUNT unchanged, OVERFLOW set.
- LIFO: stack pointer sp=COUNT; push writes mem[sp]; pop reads mem[sp-1].
- FIFO: separate wr_ptr/rd_ptr, each increments modulo DEPTH on accept; wrap from DEPTH-1 to 0.
- Simultaneous PUSH and POP:
  - LIFO, COUNT>0 (including FULL): dataOut = current top (pre-push value), dataIn overwrites that slot, COUNT unchanged, no flags.
  - FIFO, COUNT>0 (including FULL): both accepted, both pointers advance, COUNT unchanged, no flags.
  - Either mode, COUNT==0: push accepted, pop rejected, UNDERFLOW set, COUNT=1, VALID=0. No bypass of dataIn to dataOut.
- Mode change: MODE is copied into ACT_MODE only on an edge where COUNT==0 and no push is accepted; otherwise ACT_MODE holds. Stored data is never reinterpreted. On FIFO->LIFO or LIFO->FIFO switch, all pointers are 0.
- CLR_ERR=1 clears OVERFLOW/UNDERFLOW on the next edge; a new error in the same cycle wins (flag stays set).
- COUNT never exceeds DEPTH and never goes below 0.

Optional Feature:
LIFO_FIFO_BUFFER_FIFO_MODE_EN:
- Defined: behaviour as above; MODE selects LIFO/FIFO.
- Undefined: FIFO pointer logic is not synthesised, MODE is ignored, ACT_MODE is tied to 0, and the block is LIFO-only. All other ports and behaviour are unchanged.

Test Plan:
- LIFO fill/drain: reset, MODE=0, push 0x00..0x0F over 16 cycles -> FULL=1, COUNT=16; then 16 pops -> dataOut 0x0F..0x00, each with VALID one cycle after its POP; EMPTY=1 at end.
- FIFO order and wrap: MODE=1 while empty; push 0x00..0x0F, pop 8, push 0x10..0x17, pop 16 -> dataOut 0x00..0x17 in order; pointers wrap with no loss.
- Overflow and underflow: with FULL, push 0xAA -> OVERFLOW=1, COUNT stays 16, contents unchanged. Drain, then pop when empty -> UNDERFLOW=1, VALID=0. Assert CLR_ERR -> both flags 0 next cycle.
- Simultaneous push/pop: LIFO holding 0x01,0x02; push 0x33 with pop -> dataOut=0x02, COUNT=2; next pop returns 0x33. When empty, push+pop -> COUNT=1, UNDERFLOW=1.
- Mode lock: with COUNT=3 in LIFO, drive MODE=1 -> ACT_MODE stays 0. After draining, ACT_MODE=1 on the next edge. ALMOST_FULL asserts at COUNT=12, not at 11.
- Reset mid-operation: with COUNT=9, pulse Rst low between clock edges -> immediately COUNT=0, EMPTY=1, flags 0, dataOut=0.
